univ_shift_reg: RTL and testbench

Parametrised universal shift register, successor to the fixed 4-bit serial-in shift register. It supports hold, shift left and right, rotate left and right, parallel load and clear, with serial in and out at both ends. A shift counter raises a one-cycle word_done pulse after every WIDTH shift or rotate operations, so the block can act as a serialiser or deserialiser for downstream lab blocks.

---
 rtl/univ_shift_reg_pkg.sv | 12 +
 rtl/usr_shift_cnt.sv | 29 ++
 rtl/univ_shift_reg.sv | 88 ++++++++
 tb/tb_univ_shift_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings for the universal shift register.
// Imported by the RTL and the bench.
`timescale 1ns/1ps
package univ_shift_reg_pkg;
   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_ROR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;
   localparam logic [2:0] MODE_CLR  = 3'b110;
endpackage

// File: rtl/usr_shift_cnt.sv
// Modulo-WIDTH operation counter with synchronous clear
// and a combinational wrap pulse on the last increment.
`timescale 1ns/1ps
module usr_shift_cnt #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          wrap
);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   assign wrap = inc & (cnt == LAST);

   // explicit wrap keeps non-power-of-two widths correct
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= wrap ? '0 : cnt + CW'(1);
      end
   end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, load, clear,
// with a word_done pulse every WIDTH shift/rotate operations.
`timescale 1ns/1ps
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter int               CW      = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic [CW-1:0]    shift_cnt,
   output logic             word_done
);
   logic [WIDTH-1:0] q_nxt;
   logic             shift_op;
   logic             clr_op;
   logic             wrap;

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

   always_comb begin
      q_nxt    = q;
      shift_op = 1'b0;
      clr_op   = 1'b0;
      case (mode)
         MODE_HOLD: ;
         MODE_SHR: begin
            q_nxt    = {sin_l, q[WIDTH-1:1]};
            shift_op = 1'b1;
         end
         MODE_SHL: begin
            q_nxt    = {q[WIDTH-2:0], sin_r};
            shift_op = 1'b1;
         end
         MODE_ROR: begin
            q_nxt    = {q[0], q[WIDTH-1:1]};
            shift_op = 1'b1;
         end
         MODE_ROL: begin
            q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
            shift_op = 1'b1;
         end
         MODE_LOAD: begin
            q_nxt  = pdata;
            clr_op = 1'b1;
         end
         MODE_CLR: begin
            q_nxt  = RST_VAL;
            clr_op = 1'b1;
         end
         default: ;
      endcase
   end

   usr_shift_cnt #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (en & clr_op),
      .inc  (en & shift_op),
      .cnt  (shift_cnt),
      .wrap (wrap)
   );

   // wrap already carries en, so word_done drops whenever en is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q         <= RST_VAL;
         word_done <= 1'b0;
      end else begin
         word_done <= wrap;
         if (en) q <= q_nxt;
      end
   end
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: WIDTH=4 and WIDTH=8
// instances checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_univ_shift_reg;
   import univ_shift_reg_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_en, a_sl, a_sr, a_soutl, a_soutr, a_wd;
   logic [2:0] a_mode;
   logic [3:0] a_pd, a_q;
   logic [1:0] a_cnt;

   logic       b_rst, b_en, b_sl, b_sr, b_soutl, b_soutr, b_wd;
   logic [2:0] b_mode;
   logic [7:0] b_pd, b_q;
   logic [2:0] b_cnt;

   univ_shift_reg #(.WIDTH(4)) dut_a (
      .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode),
      .sin_l(a_sl), .sin_r(a_sr), .pdata(a_pd), .q(a_q),
      .sout_l(a_soutl), .sout_r(a_soutr),
      .shift_cnt(a_cnt), .word_done(a_wd)
   );

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut_b (
      .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode),
      .sin_l(b_sl), .sin_r(b_sr), .pdata(b_pd), .q(b_q),
      .sout_l(b_soutl), .sout_r(b_soutr),
      .shift_cnt(b_cnt), .word_done(b_wd)
   );

   typedef struct {
      int q;
      int c;
      bit wd;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   ma_q, ma_c, mb_q, mb_c;
   bit   ma_w, mb_w;

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Reference: each mode's effect on the integer value of q.
   function automatic void step(
      input int w, input int rv, input int q, input int c,
      input bit en, input logic [2:0] m, input bit sl,
      input bit sr, input int pd,
      output int nq, output int nc, output bit nw);
      int mask;
      bit counted;
      mask    = (1 << w) - 1;
      counted = 1'b0;
      nq      = q;
      nc      = c;
      nw      = 1'b0;
      if (!en) return;
      case (m)
         MODE_SHR: begin
            nq = (q >> 1) | (int'(sl) << (w - 1));
            counted = 1'b1;
         end
         MODE_SHL: begin
            nq = ((q << 1) | int'(sr)) & mask;
            counted = 1'b1;
         end
         MODE_ROR: begin
            nq = (q >> 1) | ((q & 1) << (w - 1));
            counted = 1'b1;
         end
         MODE_ROL: begin
            nq = ((q << 1) | (q >> (w - 1))) & mask;
            counted = 1'b1;
         end
         MODE_LOAD: begin
            nq = pd & mask;
            nc = 0;
         end
         MODE_CLR: begin
            nq = rv;
            nc = 0;
         end
         default: ;
      endcase
      if (counted) begin
         nw = (c == w - 1);
         nc = (c + 1) % w;
      end
   endfunction

   task automatic cyc_a(bit en, logic [2:0] m, bit sl, bit sr,
                        int pd);
      exp_t e;
      @(negedge clk);
      a_en = en; a_mode = m; a_sl = sl; a_sr = sr;
      a_pd = 4'(pd);
      step(4, 0, ma_q, ma_c, en, m, sl, sr, pd, ma_q, ma_c, ma_w);
      e.q = ma_q; e.c = ma_c; e.wd = ma_w;
      qa.push_back(e);
   endtask

   task automatic cyc_b(bit en, logic [2:0] m, bit sl, bit sr,
                        int pd);
      exp_t e;
      @(negedge clk);
      b_en = en; b_mode = m; b_sl = sl; b_sr = sr;
      b_pd = 8'(pd);
      step(8, 'hA5, mb_q, mb_c, en, m, sl, sr, pd,
           mb_q, mb_c, mb_w);
      e.q = mb_q; e.c = mb_c; e.wd = mb_w;
      qb.push_back(e);
   endtask

   // Asynchronous reset asserted away from any clock edge.
   task automatic reset_a();
      @(negedge clk);
      #2 a_rst = 1'b1;
      #1;
      chk("a_rst_q", a_q, 0);
      chk("a_rst_cnt", a_cnt, 0);
      chk("a_rst_wd", a_wd, 0);
      ma_q = 0; ma_c = 0; ma_w = 1'b0;
      a_en = 1'b0;
      @(negedge clk);
      a_rst = 1'b0;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         chk("a_q", a_q, e.q);
         chk("a_cnt", a_cnt, e.c);
         chk("a_wd", a_wd, e.wd);
         chk("a_sout_l", a_soutl, (e.q >> 3) & 1);
         chk("a_sout_r", a_soutr, e.q & 1);
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         chk("b_q", b_q, e.q);
         chk("b_cnt", b_cnt, e.c);
         chk("b_wd", b_wd, e.wd);
         chk("b_sout_l", b_soutl, (e.q >> 7) & 1);
         chk("b_sout_r", b_soutr, e.q & 1);
      end
   end

   initial begin
      logic [3:0] shl_bits;
      logic [3:0] shr_bits;
      logic [6:0] b_bits;
      shl_bits = 4'b1011;
      shr_bits = 4'b1101;
      b_bits   = 7'b0101000;
      a_rst = 1'b1; a_en = 1'b0; a_mode = MODE_HOLD;
      a_sl = 1'b0; a_sr = 1'b0; a_pd = '0;
      b_rst = 1'b1; b_en = 1'b0; b_mode = MODE_HOLD;
      b_sl = 1'b0; b_sr = 1'b0; b_pd = '0;
      ma_q = 0; ma_c = 0; ma_w = 1'b0;
      mb_q = 'hA5; mb_c = 0; mb_w = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("init_a_q", a_q, 0);
      chk("init_a_cnt", a_cnt, 0);
      chk("init_a_wd", a_wd, 0);
      chk("init_b_q", b_q, 'hA5);
      chk("init_b_cnt", b_cnt, 0);
      @(negedge clk);
      a_rst = 1'b0; b_rst = 1'b0;

      // q=1011, shift_cnt=2, then reset mid-cycle
      cyc_a(1, MODE_LOAD, 0, 0, 'b1110);
      cyc_a(1, MODE_ROR, 0, 0, 0);
      cyc_a(1, MODE_ROR, 0, 0, 0);
      reset_a();

      for (int i = 3; i >= 0; i--)
         cyc_a(1, MODE_SHL, 0, shl_bits[i], 0);
      cyc_a(1, MODE_CLR, 0, 0, 0);
      for (int i = 3; i >= 0; i--)
         cyc_a(1, MODE_SHR, shr_bits[i], 0, 0);

      cyc_a(1, MODE_LOAD, 0, 0, 'b1011);
      repeat (4) cyc_a(1, MODE_ROR, 0, 0, 0);
      repeat (4) cyc_a(1, MODE_ROL, 0, 0, 0);

      repeat (2) cyc_a(1, MODE_SHL, 0, 1, 0);
      repeat (3) cyc_a(0, MODE_SHL, 0, 1, 0);
      cyc_a(1, MODE_LOAD, 0, 0, 'b0110);
      cyc_a(0, MODE_HOLD, 0, 0, 0);

      cyc_b(1, MODE_CLR, 0, 0, 0);
      for (int i = 6; i >= 0; i--)
         cyc_b(1, MODE_SHL, 0, b_bits[i], 0);
      cyc_b(1, 3'b111, 0, 0, 0);
      cyc_b(1, MODE_SHL, 0, 1, 0);
      @(posedge clk);
      #2;
      chk("t6_q", b_q, 'h51);
      chk("t6_cnt", b_cnt, 0);
      chk("t6_wd", b_wd, 1);
      cyc_b(0, MODE_HOLD, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 29) == 0)
            reset_a();
         else
            cyc_a($urandom_range(0, 7) != 0,
                  3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)));
      end
      cyc_a(0, MODE_HOLD, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         cyc_b($urandom_range(0, 7) != 0,
               3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               int'($urandom_range(0, 255)));

      repeat (4) @(posedge clk);
      #3;
      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
